// File: rtl/z80_block_compare_engine.sv
// Execution unit for the Z80 block-compare family (CPI, CPD, CPIR, CPDR).
// Fetches its own operands over a req/ack read port and loops internally for repeating modes.
module z80_block_compare_engine #(
    parameter int ADDR_W  = 16,
    parameter int CNT_W   = 16,
    parameter int YIELD_N = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mode_dec,
    input  logic              mode_rep,
    input  logic [7:0]        a_in,
    input  logic [7:0]        f_in,
    input  logic [ADDR_W-1:0] hl_in,
    input  logic [CNT_W-1:0]  bc_in,
    input  logic              irq_pending,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] hl_out,
    output logic [CNT_W-1:0]  bc_out,
    output logic [7:0]        f_out,
    output logic              advance_ip,
    output logic [CNT_W-1:0]  iter_count
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EVAL,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] YIELD_CNT = CNT_W'(YIELD_N);

    state_t            state;
    logic [7:0]        a_reg;
    logic [7:0]        f_reg;
    logic [7:0]        m_reg;
    logic [ADDR_W-1:0] hl_reg;
    logic [CNT_W-1:0]  bc_reg;
    logic              dec_reg;
    logic              rep_reg;

    logic [7:0]        diff;
    logic              zero;
    logic              half;
    logic [ADDR_W-1:0] hl_next;
    logic [CNT_W-1:0]  bc_next;
    logic [CNT_W-1:0]  iter_next;
    logic [7:0]        f_next;
    logic              finish_adv;
    logic              finish_yield;

    // One compare step: flags in Z80 order S Z 5 H 3 P/V N C, with 5, 3 and C passed through
    assign diff      = a_reg - m_reg;
    assign zero      = (diff == 8'h00);
    assign half      = (a_reg[3:0] < m_reg[3:0]);
    assign hl_next   = dec_reg ? (hl_reg - ADDR_W'(1)) : (hl_reg + ADDR_W'(1));
    assign bc_next   = bc_reg - CNT_W'(1);
    assign iter_next = iter_count + CNT_W'(1);
    assign f_next    = {diff[7], zero, f_reg[5], half, f_reg[3], (bc_next != '0), 1'b1, f_reg[0]};

    // Natural completion outranks a yield, so a found match or exhausted count always advances IP
    assign finish_adv   = !rep_reg || (bc_next == '0) || zero;
    assign finish_yield = irq_pending || ((YIELD_N != 0) && (iter_next == YIELD_CNT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            a_reg      <= '0;
            f_reg      <= '0;
            m_reg      <= '0;
            hl_reg     <= '0;
            bc_reg     <= '0;
            dec_reg    <= 1'b0;
            rep_reg    <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            hl_out     <= '0;
            bc_out     <= '0;
            f_out      <= '0;
            advance_ip <= 1'b0;
            iter_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg      <= a_in;
                        f_reg      <= f_in;
                        hl_reg     <= hl_in;
                        bc_reg     <= bc_in;
                        dec_reg    <= mode_dec;
                        rep_reg    <= mode_rep;
                        iter_count <= '0;
                        advance_ip <= 1'b0;
                        mem_req    <= 1'b1;
                        mem_addr   <= hl_in;
                        busy       <= 1'b1;
                        state      <= READ;
                    end
                end

                READ: begin
                    if (mem_ack) begin
                        m_reg   <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= EVAL;
                    end
                end

                EVAL: begin
                    hl_reg     <= hl_next;
                    bc_reg     <= bc_next;
                    f_reg      <= f_next;
                    hl_out     <= hl_next;
                    bc_out     <= bc_next;
                    f_out      <= f_next;
                    iter_count <= iter_next;
                    if (finish_adv) begin
                        advance_ip <= 1'b1;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end else if (finish_yield) begin
                        advance_ip <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_addr <= hl_next;
                        state    <= READ;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z80_block_compare_engine.sv
// Directed bench for z80_block_compare_engine: a behavioural memory responder plus a
// reference model that queues expected read addresses and final results per start.
module tb_z80_block_compare_engine;

    localparam int YIELD = 4;

    typedef struct packed {
        logic [15:0] hl;
        logic [15:0] bc;
        logic [7:0]  f;
        logic        adv;
        logic [15:0] iter;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        mode_dec;
    logic        mode_rep;
    logic [7:0]  a_in;
    logic [7:0]  f_in;
    logic [15:0] hl_in;
    logic [15:0] bc_in;
    logic        irq_pending;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        done;
    logic [15:0] hl_out;
    logic [15:0] bc_out;
    logic [7:0]  f_out;
    logic        advance_ip;
    logic [15:0] iter_count;

    logic        resp_ack;
    logic        late_ack;
    logic [7:0]  resp_data;
    int          ack_delay;
    int          wait_cnt;
    int          reads_started;

    logic [7:0]  mem [0:65535];
    exp_t        exp_q[$];
    logic [15:0] exp_addr[$];
    exp_t        mon_e;

    int          n_checks;
    int          n_fail;

    assign mem_ack   = resp_ack | late_ack;
    assign mem_rdata = resp_data;

    z80_block_compare_engine #(
        .ADDR_W (16),
        .CNT_W  (16),
        .YIELD_N(YIELD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .mode_dec   (mode_dec),
        .mode_rep   (mode_rep),
        .a_in       (a_in),
        .f_in       (f_in),
        .hl_in      (hl_in),
        .bc_in      (bc_in),
        .irq_pending(irq_pending),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .hl_out     (hl_out),
        .bc_out     (bc_out),
        .f_out      (f_out),
        .advance_ip (advance_ip),
        .iter_count (iter_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        n_checks++;
        n_fail++;
        $error("[TB] FAIL %s observed=timeout/none expected=event", tag);
    endtask

    // Reference model: walks memory exactly as the engine should, queueing addresses and the result
    task automatic push_expect(input logic [7:0] a, input logic [7:0] f, input logic [15:0] hl,
                               input logic [15:0] bc, input logic dec, input logic rep,
                               input int irq_iter);
        exp_t        e;
        logic [7:0]  m;
        logic [7:0]  d;
        logic [15:0] h;
        logic [15:0] b;
        logic [7:0]  fw;
        int          it;
        bit          stop;
        h    = hl;
        b    = bc;
        fw   = f;
        it   = 0;
        stop = 0;
        e    = '0;
        while (!stop) begin
            exp_addr.push_back(h);
            m  = mem[h];
            d  = a - m;
            b  = b - 16'd1;
            h  = dec ? h - 16'd1 : h + 16'd1;
            it++;
            fw = {d[7], (d == 8'h00), fw[5], (a[3:0] < m[3:0]), fw[3], (b != 16'h0), 1'b1, fw[0]};
            if (!rep || b == 16'h0 || d == 8'h00) begin
                e.adv = 1'b1;
                stop  = 1;
            end else if (it == irq_iter || it == YIELD) begin
                e.adv = 1'b0;
                stop  = 1;
            end
        end
        e.hl   = h;
        e.bc   = b;
        e.f    = fw;
        e.iter = 16'(it);
        exp_q.push_back(e);
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] f, input logic [15:0] hl,
                            input logic [15:0] bc, input logic dec, input logic rep);
        @(negedge clk);
        a_in     = a;
        f_in     = f;
        hl_in    = hl;
        bc_in    = bc;
        mode_dec = dec;
        mode_rep = rep;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        bit got;
        got = 0;
        lat = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (done) got = 1;
        end
        if (!got) begin
            fail_now("done_timeout");
            exp_q.delete();
            exp_addr.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string pfx);
        check({pfx, "_mem_req"},    mem_req,    0);
        check({pfx, "_mem_addr"},   mem_addr,   0);
        check({pfx, "_busy"},       busy,       0);
        check({pfx, "_done"},       done,       0);
        check({pfx, "_advance_ip"}, advance_ip, 0);
        check({pfx, "_hl_out"},     hl_out,     0);
        check({pfx, "_bc_out"},     bc_out,     0);
        check({pfx, "_f_out"},      f_out,      0);
        check({pfx, "_iter_count"}, iter_count, 0);
    endtask

    // Memory responder: acks after ack_delay wait cycles and checks each read address
    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            if (wait_cnt == 0) reads_started++;
            if (wait_cnt >= ack_delay) begin
                resp_ack  = 1'b1;
                resp_data = mem[mem_addr];
                wait_cnt  = 0;
                if (exp_addr.size() == 0) fail_now("read_unexpected");
                else check("read_addr", mem_addr, exp_addr.pop_front());
            end else begin
                resp_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            resp_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    // Result monitor: compares every done pulse against the oldest queued expectation
    always @(negedge clk) begin
        if (reset_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                fail_now("done_unexpected");
            end else begin
                mon_e = exp_q.pop_front();
                check("hl_out",     hl_out,     mon_e.hl);
                check("bc_out",     bc_out,     mon_e.bc);
                check("f_out",      f_out,      mon_e.f);
                check("advance_ip", advance_ip, mon_e.adv);
                check("iter_count", iter_count, mon_e.iter);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int lat;
        int act;
        n_checks      = 0;
        n_fail        = 0;
        reads_started = 0;
        wait_cnt      = 0;
        ack_delay     = 0;
        resp_ack      = 1'b0;
        late_ack      = 1'b0;
        resp_data     = 8'h00;
        start         = 1'b0;
        mode_dec      = 1'b0;
        mode_rep      = 1'b0;
        a_in          = 8'h00;
        f_in          = 8'h00;
        hl_in         = 16'h0000;
        bc_in         = 16'h0000;
        irq_pending   = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEE;
        mem[16'h4000] = 8'h20;
        mem[16'h1003] = 8'h00;
        mem[16'h1002] = 8'h11;
        mem[16'h1001] = 8'h55;
        mem[16'h1000] = 8'h77;
        mem[16'h5000] = 8'h05;

        reset_n = 1'b1;
        #3 reset_n = 1'b0;
        #1 check_zero_outputs("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // CPI single step, zero-wait memory
        push_expect(8'h10, 8'h29, 16'h4000, 16'h0002, 1'b0, 1'b0, 0);
        start_op(8'h10, 8'h29, 16'h4000, 16'h0002, 1'b0, 1'b0);
        check("cpi_req_after_start", mem_req, 1);
        check("cpi_busy_after_start", busy, 1);
        check("cpi_first_addr", mem_addr, 16'h4000);
        wait_done(lat);
        check("cpi_latency", lat, 3);
        repeat (2) @(negedge clk);
        check("cpi_hold_hl", hl_out, 16'h4001);
        check("cpi_idle_busy", busy, 0);

        // CPDR finds a match on the third byte, one wait cycle per read
        ack_delay = 1;
        push_expect(8'h55, 8'h00, 16'h1003, 16'h0005, 1'b1, 1'b1, 0);
        start_op(8'h55, 8'h00, 16'h1003, 16'h0005, 1'b1, 1'b1);
        wait_done(lat);

        // CPIR exhausts BC; a second start mid-run must be ignored
        ack_delay = 0;
        push_expect(8'h42, 8'hFF, 16'h2000, 16'h0003, 1'b0, 1'b1, 0);
        start_op(8'h42, 8'hFF, 16'h2000, 16'h0003, 1'b0, 1'b1);
        @(negedge clk);
        hl_in = 16'h7777;
        bc_in = 16'h0001;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat);

        // CPD with irq high: interrupts do not affect non-repeat forms
        irq_pending = 1'b1;
        push_expect(8'h31, 8'h00, 16'h5000, 16'h0001, 1'b1, 1'b0, 0);
        start_op(8'h31, 8'h00, 16'h5000, 16'h0001, 1'b1, 1'b0);
        wait_done(lat);
        irq_pending = 1'b0;

        // CPIR interrupted: irq raised while the second read is waiting
        ack_delay = 2;
        push_expect(8'h42, 8'h28, 16'h3000, 16'h000A, 1'b0, 1'b1, 2);
        reads_started = 0;
        start_op(8'h42, 8'h28, 16'h3000, 16'h000A, 1'b0, 1'b1);
        for (int i = 0; i < 50 && reads_started < 2; i++) begin
            @(posedge clk);
            #2;
        end
        if (reads_started < 2) fail_now("irq_second_read_timeout");
        irq_pending = 1'b1;
        wait_done(lat);
        irq_pending = 1'b0;

        // Full-count run wrapping HL past FFFF, stopped by the burst limit
        ack_delay = 0;
        push_expect(8'h42, 8'h00, 16'hFFFE, 16'h0000, 1'b0, 1'b1, 0);
        start_op(8'h42, 8'h00, 16'hFFFE, 16'h0000, 1'b0, 1'b1);
        wait_done(lat);

        // Reset during a long ack wait, then a stray late ack
        ack_delay = 5;
        start_op(8'h10, 8'h00, 16'h6000, 16'h0004, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("rst_pre_req", mem_req, 1);
        #2 reset_n = 1'b0;
        #1 check_zero_outputs("rst_mid");
        @(negedge clk);
        #2 reset_n = 1'b1;
        ack_delay = 0;
        late_ack  = 1'b1;
        @(posedge clk);
        #1 late_ack = 1'b0;
        act = 0;
        repeat (4) begin
            @(negedge clk);
            if (mem_req || busy || done) act++;
        end
        check("late_ack_quiet", act, 0);

        // Fresh CPI after reset
        push_expect(8'h10, 8'h29, 16'h4000, 16'h0002, 1'b0, 1'b0, 0);
        start_op(8'h10, 8'h29, 16'h4000, 16'h0002, 1'b0, 1'b0);
        wait_done(lat);
        check("post_rst_latency", lat, 3);

        repeat (2) @(negedge clk);
        check("sb_results_drained", exp_q.size(), 0);
        check("sb_addrs_drained", exp_addr.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
